pipe_skid_stage: RTL and testbench

- Parametrised successor to the fixed MEM/WB-style pipeline register.
- Carries instruction, PC and a generic payload between two pipeline stages using a valid/ready handshake instead of a bare write enable.
- A two-entry skid buffer gives full throughput with a registered in_ready; a synchronous flush inserts a bubble.
- Instantiated between any pair of CPU stages; also keeps stall and bubble performance counters.

---
 rtl/pipe_skid_stage.sv | 156 +++++++++++++++
 tb/tb_pipe_skid_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Pipeline register between two CPU stages with a valid/ready handshake.
//   A main entry drives the outputs. A skid entry catches the one extra beat
//   that can arrive while in_ready (registered) is still high during
//   backpressure. The stage also keeps saturating stall and bubble counters.
//
// Ports
//   clk, reset          : clock; synchronous active-high reset
//   flush               : synchronous flush; drops held entries and any concurrent input beat
//   in_valid/in_ready   : upstream handshake (in_ready decoded from state flops only)
//   in_instr/pc/payload : upstream beat fields
//   out_valid/out_ready : downstream handshake
//   out_instr/pc/payload: main entry fields (out_instr reads 0 while out_valid=0)
//   stall_cnt           : cycles with out_valid=1 and out_ready=0
//   bubble_cnt          : cycles with out_valid=0
module pipe_skid_stage #(
    parameter int unsigned PAYLOAD_W = 96,
    parameter int unsigned INSTR_W   = 32,
    parameter int unsigned PC_W      = 32,
    parameter logic [PC_W-1:0] PC_RESET = PC_W'(32'h0000_3000),
    parameter int unsigned CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [PC_W-1:0]      out_pc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_BUSY,
        ST_FULL
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
    logic [PC_W-1:0]      main_pc_q, main_pc_d;
    logic [PAYLOAD_W-1:0] main_payload_q, main_payload_d;
    logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
    logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;

    logic in_fire;
    logic out_fire;

    assign in_ready    = (state_q != ST_FULL);
    assign out_valid   = (state_q != ST_EMPTY);
    assign out_instr   = out_valid ? main_instr_q : '0;
    assign out_pc      = main_pc_q;
    assign out_payload = main_payload_q;
    assign stall_cnt   = stall_cnt_q;
    assign bubble_cnt  = bubble_cnt_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_instr_d   = main_instr_q;
        main_pc_d      = main_pc_q;
        main_payload_d = main_payload_q;
        skid_instr_d   = skid_instr_q;
        skid_pc_d      = skid_pc_q;
        skid_payload_d = skid_payload_q;

        if (flush) begin
            // The PC and payload stay visible; only the instruction becomes a
            // nop. A concurrent input beat is dropped and the skid entry is
            // abandoned.
            state_d      = ST_EMPTY;
            main_instr_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_instr_d   = in_instr;
                        main_pc_d      = in_pc;
                        main_payload_d = in_payload;
                        state_d        = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_instr_d   = in_instr;
                        main_pc_d      = in_pc;
                        main_payload_d = in_payload;
                    end else if (in_fire) begin
                        skid_instr_d   = in_instr;
                        skid_pc_d      = in_pc;
                        skid_payload_d = in_payload;
                        state_d        = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_instr_d   = skid_instr_q;
                        main_pc_d      = skid_pc_q;
                        main_payload_d = skid_payload_q;
                        state_d        = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Counters sample the current-cycle handshake and saturate at all-ones.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!out_valid && (bubble_cnt_q != '1))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        if (out_valid && !out_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_EMPTY;
            main_instr_q   <= '0;
            main_pc_q      <= PC_RESET;
            main_payload_q <= '0;
            skid_instr_q   <= '0;
            skid_pc_q      <= '0;
            skid_payload_q <= '0;
            stall_cnt_q    <= '0;
            bubble_cnt_q   <= '0;
        end else begin
            state_q        <= state_d;
            main_instr_q   <= main_instr_d;
            main_pc_q      <= main_pc_d;
            main_payload_q <= main_payload_d;
            skid_instr_q   <= skid_instr_d;
            skid_pc_q      <= skid_pc_d;
            skid_payload_q <= skid_payload_d;
            stall_cnt_q    <= stall_cnt_d;
            bubble_cnt_q   <= bubble_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage
//   Directed bench for pipe_skid_stage with CNT_W=4, so counter saturation is
//   reachable. A scoreboard queue holds accepted beats. Outputs, handshake and
//   counters are compared every cycle against that queue and the bench's
//   saturating counter model.
module tb_pipe_skid_stage;

    localparam int unsigned PAYLOAD_W = 96;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned CNT_MAX   = 15;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [INSTR_W-1:0]   in_instr;
    logic [PC_W-1:0]      in_pc;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 out_valid;
    logic                 out_ready;
    logic [INSTR_W-1:0]   out_instr;
    logic [PC_W-1:0]      out_pc;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     bubble_cnt;

    pipe_skid_stage #(
        .PAYLOAD_W(PAYLOAD_W),
        .INSTR_W  (INSTR_W),
        .PC_W     (PC_W),
        .PC_RESET (32'h0000_3000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_payload(out_payload),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [INSTR_W-1:0]   instr;
        logic [PC_W-1:0]      pc;
        logic [PAYLOAD_W-1:0] pl;
    } beat_t;

    beat_t                q[$];
    logic [PC_W-1:0]      last_pc;
    logic [PAYLOAD_W-1:0] last_pl;
    int unsigned          m_stall;
    int unsigned          m_bubble;
    int unsigned          n_checks;
    int unsigned          n_fail;
    int unsigned          n_emitted;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_pc  = 32'h0000_3000;
        last_pl  = '0;
        m_stall  = 0;
        m_bubble = 0;
    endtask

    // Called at a negedge; applies reset for two cycles and returns at a negedge.
    task automatic do_reset();
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One cycle: drive inputs at the negedge, compare, step the model across
    // the posedge, and return at the next negedge.
    task automatic step(input bit v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [95:0] pl, input bit ordy, input bit fl);
        bit    exp_in_fire, exp_out_fire;
        beat_t b;
        in_valid   = v;
        in_instr   = instr;
        in_pc      = pc;
        in_payload = pl;
        out_ready  = ordy;
        flush      = fl;
        #1;
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("out_instr", out_instr, (q.size() > 0) ? q[0].instr : 32'h0);
        chk("out_pc", out_pc, (q.size() > 0) ? q[0].pc : last_pc);
        chk("out_payload", out_payload, (q.size() > 0) ? q[0].pl : last_pl);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("bubble_cnt", bubble_cnt, m_bubble);

        exp_in_fire  = v && (q.size() < 2);
        exp_out_fire = (q.size() > 0) && ordy;
        if (q.size() == 0) begin
            if (m_bubble < CNT_MAX) m_bubble++;
        end else if (!ordy) begin
            if (m_stall < CNT_MAX) m_stall++;
        end
        @(posedge clk);
        if (exp_out_fire) begin
            b = q.pop_front();
            n_emitted++;
        end
        if (fl) begin
            q.delete();
        end else if (exp_in_fire) begin
            b.instr = instr;
            b.pc    = pc;
            b.pl    = pl;
            q.push_back(b);
        end
        if (q.size() > 0) begin
            last_pc = q[0].pc;
            last_pl = q[0].pl;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 32'h0, 32'h0, 96'h0, ordy, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_emitted = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        in_payload = '0;
        @(negedge clk);

        // Reset values
        do_reset();
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h3000);
        chk("rst_out_payload", out_payload, 96'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_stall", stall_cnt, 4'd0);
        chk("rst_bubble", bubble_cnt, 4'd0);

        // Streaming, out_ready held high
        for (int i = 1; i <= 5; i++)
            step(1'b1, 32'(i), 32'h3000 + 32'(4 * (i - 1)), {64'(i), 32'hA5A5_0000 + 32'(i)}, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("stream_emitted", n_emitted, 5);
        chk("stream_stall", stall_cnt, 4'd0);

        // Backpressure: A then B into a stalled stage, then drain
        do_reset();
        step(1'b1, 32'hAAAA_0001, 32'h3000, 96'hA, 1'b0, 1'b0);
        step(1'b1, 32'hBBBB_0002, 32'h3004, 96'hB, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_0003, 32'h3008, 96'hD, 1'b0, 1'b0);  // refused while FULL
        idle(1'b0);
        chk("bp_full_in_ready", in_ready, 1'b0);
        chk("bp_hold_instr", out_instr, 32'hAAAA_0001);
        chk("bp_stall", stall_cnt, 4'd3);
        idle(1'b1);
        chk("bp_in_ready_back", in_ready, 1'b1);
        chk("bp_second_instr", out_instr, 32'hBBBB_0002);
        idle(1'b1);
        idle(1'b1);

        // Flush while FULL with a concurrent input beat
        step(1'b1, 32'h1111_0001, 32'h3100, 96'h11, 1'b0, 1'b0);
        step(1'b1, 32'h2222_0002, 32'h3104, 96'h22, 1'b0, 1'b0);
        step(1'b1, 32'h3333_0003, 32'h3108, 96'h33, 1'b0, 1'b1);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_instr", out_instr, 32'h0);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_pc_kept", out_pc, 32'h3100);
        step(1'b1, 32'hCCCC_0004, 32'h310C, 96'hCC, 1'b1, 1'b0);
        chk("flush_next_instr", out_instr, 32'hCCCC_0004);
        idle(1'b1);

        // Simultaneous in_fire and out_fire in BUSY
        step(1'b1, 32'h5000_0000, 32'h3200, 96'h50, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++)
            step(1'b1, 32'h5000_0000 + 32'(i), 32'h3200 + 32'(4 * i), 96'(i) << 8, 1'b1, 1'b0);
        chk("busy_in_ready", in_ready, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Short randomised mix
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), $urandom(), $urandom(), {$urandom(), $urandom(), $urandom()},
                 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

        // Counter saturation
        do_reset();
        repeat (20) idle(1'b0);
        chk("sat_bubble", bubble_cnt, 4'd15);
        step(1'b0, 32'h0, 32'h0, 96'h0, 1'b0, 1'b1);
        chk("sat_after_flush", bubble_cnt, 4'd15);
        do_reset();
        #1;
        chk("sat_after_reset", bubble_cnt, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
